// File: rtl/roc_lane_pkg.sv
// Shared constants and FSM encoding for the ROC lane-select path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package roc_lane_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PENDING  = 2'd2
    } lane_state_t;

    // Lane-mask width on the ROC
    localparam int ROC_NLANE = 4;

    // Source indices; lower index wins
    localparam int SRC_DCS    = 0;
    localparam int SRC_SERIAL = 1;

    // Width of a source index, never narrower than one bit
    function automatic int src_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/use_lane_prio_sel.sv
// Priority encoder: picks the lowest-index source driving a non-zero lane mask.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
module use_lane_prio_sel
    import roc_lane_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int NLANE = ROC_NLANE,
    parameter int SRCW  = src_width(NSRC)
) (
    input  logic [NSRC*NLANE-1:0] src_lanes,
    output logic                  cand_valid,
    output logic [SRCW-1:0]       cand_src,
    output logic [NLANE-1:0]      cand_mask
);

    // Scan from lowest priority upward so the highest-priority hit is written last
    always_comb begin
        cand_valid = 1'b0;
        cand_src   = '0;
        cand_mask  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_lanes[i*NLANE +: NLANE] != '0) begin
                cand_valid = 1'b1;
                cand_src   = SRCW'(i);
                cand_mask  = src_lanes[i*NLANE +: NLANE];
            end
        end
    end

endmodule

// File: rtl/use_lane_arbiter.sv
// Debounced lane-mask arbiter; optional switch counter under USE_LANE_SWITCH_CNT_EN.
// Latency: a steady new candidate applies STABLE_CYC edges after the edge that first samples it, if safe_i.
// Backpressure: safe_i low holds a debounced change in PENDING indefinitely; no timeout.
module use_lane_arbiter
    import roc_lane_pkg::*;
#(
    parameter int NSRC       = 2,
    parameter int NLANE      = ROC_NLANE,
    parameter int STABLE_CYC = 4,
    localparam int SRCW      = src_width(NSRC),
    localparam int CNTW      = $clog2(STABLE_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC*NLANE-1:0] src_lanes,
    input  logic                  safe_i,
    output logic [NLANE-1:0]      use_lane_o,
    output logic [SRCW-1:0]       active_src_o,
    output logic                  active_valid_o,
    output logic                  lane_change_o,
    output logic                  pending_o
`ifdef USE_LANE_SWITCH_CNT_EN
    ,
    output logic [15:0]           switch_cnt_o
`endif
);

    // Tuple layout: {valid, src, mask}; all fields take part in change detection
    localparam int TW = 1 + SRCW + NLANE;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STABLE_CYC - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    // With a one-cycle debounce the first sighting already satisfies stability
    localparam lane_state_t FIRST_ST = (STABLE_CYC == 1) ? ST_PENDING : ST_DEBOUNCE;

    logic              cand_valid;
    logic [SRCW-1:0]   cand_src;
    logic [NLANE-1:0]  cand_mask;

    logic [TW-1:0]     cand_t;
    logic [TW-1:0]     applied_t;
    logic [TW-1:0]     held_q;
    logic [TW-1:0]     held_d;
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   cnt_d;
    lane_state_t       state_q;
    lane_state_t       state_d;
    logic              apply;

    use_lane_prio_sel #(
        .NSRC  (NSRC),
        .NLANE (NLANE),
        .SRCW  (SRCW)
    ) u_prio_sel (
        .src_lanes  (src_lanes),
        .cand_valid (cand_valid),
        .cand_src   (cand_src),
        .cand_mask  (cand_mask)
    );

    assign cand_t    = {cand_valid, cand_src, cand_mask};
    assign applied_t = {active_valid_o, active_src_o, use_lane_o};
    assign pending_o = (state_q == ST_DEBOUNCE) || (state_q == ST_PENDING);

    // Next-state, held candidate, debounce count and apply strobe
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_t != applied_t) begin
                    held_d  = cand_t;
                    cnt_d   = CNT_ONE;
                    state_d = FIRST_ST;
                end
            end
            ST_DEBOUNCE: begin
                if (cand_t == held_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PENDING;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (cand_t == applied_t) begin
                    // Input glitched back to what is already applied
                    state_d = ST_IDLE;
                end else begin
                    held_d  = cand_t;
                    cnt_d   = CNT_ONE;
                    state_d = FIRST_ST;
                end
            end
            ST_PENDING: begin
                if (cand_t != held_q) begin
                    if (cand_t == applied_t) begin
                        state_d = ST_IDLE;
                    end else begin
                        held_d  = cand_t;
                        cnt_d   = CNT_ONE;
                        state_d = FIRST_ST;
                    end
                end else if (safe_i) begin
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, debounce bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            held_q         <= '0;
            cnt_q          <= '0;
            use_lane_o     <= '0;
            active_src_o   <= '0;
            active_valid_o <= 1'b0;
            lane_change_o  <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            cnt_q         <= cnt_d;
            lane_change_o <= apply;
            if (apply) begin
                {active_valid_o, active_src_o, use_lane_o} <= held_q;
            end
        end
    end

`ifdef USE_LANE_SWITCH_CNT_EN
    logic [15:0] switch_cnt;

    // Saturating count of applied lane changes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            switch_cnt <= '0;
        end else if (apply && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'd1;
        end
    end

    assign switch_cnt_o = switch_cnt;
`endif

endmodule

// File: tb/tb_use_lane_arbiter.sv
// Directed bench for use_lane_arbiter (NSRC=2, NLANE=4, STABLE_CYC=4).
// Latency: n/a.
// Backpressure: exercised through safe_i.
module tb_use_lane_arbiter;
    import roc_lane_pkg::*;

    localparam int NSRC  = 2;
    localparam int NLANE = 4;
    // Input driven just after an edge is first sampled at the next edge (1),
    // then needs STABLE_CYC more edges to apply: pulse seen after edge 5.
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       src_lanes;
    logic             safe_i;
    logic [3:0]       use_lane_o;
    logic [0:0]       active_src_o;
    logic             active_valid_o;
    logic             lane_change_o;
    logic             pending_o;
`ifdef USE_LANE_SWITCH_CNT_EN
    logic [15:0]      switch_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    use_lane_arbiter #(
        .NSRC       (NSRC),
        .NLANE      (NLANE),
        .STABLE_CYC (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .src_lanes      (src_lanes),
        .safe_i         (safe_i),
        .use_lane_o     (use_lane_o),
        .active_src_o   (active_src_o),
        .active_valid_o (active_valid_o),
        .lane_change_o  (lane_change_o),
        .pending_o      (pending_o)
`ifdef USE_LANE_SWITCH_CNT_EN
        ,
        .switch_cnt_o   (switch_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input logic [3:0] serial, input logic [3:0] dcs);
        src_lanes = {serial, dcs};
    endtask

    // One clock: advance to the next posedge, then sample on the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Edges until the change pulse, or -1 when the budget runs out
    task automatic wait_apply(input int budget, output int edges);
        int cnt;
        bit found;
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < budget) begin
            step();
            cnt++;
            if (lane_change_o) found = 1'b1;
        end
        edges = found ? cnt : -1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lane"},  32'(use_lane_o), 32'h0);
        chk({tag, "_src"},   32'(active_src_o), 32'h0);
        chk({tag, "_valid"}, 32'(active_valid_o), 32'h0);
        chk({tag, "_chg"},   32'(lane_change_o), 32'h0);
        chk({tag, "_pend"},  32'(pending_o), 32'h0);
    endtask

    initial begin
        // 1: reset with a live source, then release
        reset_n = 1'b0;
        safe_i  = 1'b1;
        set_src(4'h0, 4'h5);
        repeat (3) step();
        check_zero("rst");
        reset_n = 1'b1;
        wait_apply(20, n);
        chk("t1_lat", n, LAT);
        chk("t1_lane", 32'(use_lane_o), 32'h5);
        chk("t1_src", 32'(active_src_o), SRC_DCS);
        chk("t1_valid", 32'(active_valid_o), 32'h1);
        step();
        chk("t1_pulse_end", 32'(lane_change_o), 32'h0);
        chk("t1_idle", 32'(pending_o), 32'h0);

        // 2: priority handover and fallback
        set_src(4'h3, 4'h0);
        wait_apply(20, n);
        chk("t2a_lat", n, LAT);
        chk("t2a_lane", 32'(use_lane_o), 32'h3);
        chk("t2a_src", 32'(active_src_o), SRC_SERIAL);
        set_src(4'h3, 4'hC);
        wait_apply(20, n);
        chk("t2b_lat", n, LAT);
        chk("t2b_lane", 32'(use_lane_o), 32'hC);
        chk("t2b_src", 32'(active_src_o), SRC_DCS);
        set_src(4'h3, 4'h0);
        wait_apply(20, n);
        chk("t2c_lat", n, LAT);
        chk("t2c_lane", 32'(use_lane_o), 32'h3);
        chk("t2c_src", 32'(active_src_o), SRC_SERIAL);
`ifdef USE_LANE_SWITCH_CNT_EN
        chk("cnt_four", 32'(switch_cnt_o), 32'd4);
`endif

        // 3: two-cycle glitch to A is rejected
        set_src(4'h0, 4'h5);
        wait_apply(20, n);
        chk("t3_prep", 32'(use_lane_o), 32'h5);
        step();
        set_src(4'h0, 4'hA);
        step();
        chk("t3_pend1", 32'(pending_o), 32'h1);
        step();
        chk("t3_pend2", 32'(pending_o), 32'h1);
        set_src(4'h0, 4'h5);
        step();
        chk("t3_pend_drop", 32'(pending_o), 32'h0);
        pulses = 0;
        repeat (6) begin
            step();
            if (lane_change_o) pulses++;
        end
        chk("t3_no_pulse", pulses, 0);
        chk("t3_lane", 32'(use_lane_o), 32'h5);

        // 4: stable change held off by safe_i
        safe_i = 1'b0;
        set_src(4'h0, 4'h6);
        pulses = 0;
        repeat (20) begin
            step();
            if (lane_change_o) pulses++;
        end
        chk("t4_pend", 32'(pending_o), 32'h1);
        chk("t4_hold_lane", 32'(use_lane_o), 32'h5);
        chk("t4_no_pulse", pulses, 0);
        safe_i = 1'b1;
        step();
        chk("t4_lane", 32'(use_lane_o), 32'h6);
        chk("t4_pulse", 32'(lane_change_o), 32'h1);
        step();
        chk("t4_pulse_end", 32'(lane_change_o), 32'h0);

        // 5: all sources zero, then reset during PENDING
        set_src(4'h0, 4'h0);
        wait_apply(20, n);
        chk("t5_lat", n, LAT);
        chk("t5_lane", 32'(use_lane_o), 32'h0);
        chk("t5_valid", 32'(active_valid_o), 32'h0);
        chk("t5_src", 32'(active_src_o), 32'h0);
        step();
        safe_i = 1'b0;
        set_src(4'h0, 4'h9);
        repeat (5) step();
        chk("t5_pend", 32'(pending_o), 32'h1);
        reset_n = 1'b0;
        set_src(4'h0, 4'h0);
        step();
        check_zero("t5_rst");
        reset_n = 1'b1;
        safe_i  = 1'b1;
        repeat (3) step();
        chk("t5_idle", 32'(pending_o), 32'h0);

`ifdef USE_LANE_SWITCH_CNT_EN
        // 6: counter saturation
        chk("cnt_rst", 32'(switch_cnt_o), 32'd0);
        force dut.switch_cnt = 16'hFFFF;
        step();
        release dut.switch_cnt;
        set_src(4'h0, 4'h3);
        wait_apply(20, n);
        chk("cnt_lat", n, LAT);
        step();
        chk("cnt_sat", 32'(switch_cnt_o), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
